// File: rtl/fir_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_dma_pkg
// Description : Shared constants for the FIR DMA engine: register word
//               offsets, CTRL bit positions, FSM state encoding and a pointer
//               advance helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_dma_pkg;

    // Register word offsets (address bits [3:2])
    localparam logic [1:0] c_REG_CTRL = 2'd0;
    localparam logic [1:0] c_REG_SRC  = 2'd1;
    localparam logic [1:0] c_REG_DST  = 2'd2;
    localparam logic [1:0] c_REG_LEN  = 2'd3;

    // CTRL bit positions
    localparam int c_CTRL_START = 0;
    localparam int c_CTRL_DONE  = 1;
    localparam int c_CTRL_BUSY  = 2;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_RD_REQ  = 3'd1;
    localparam state_t c_ST_SS_PUSH = 3'd2;
    localparam state_t c_ST_SM_WAIT = 3'd3;
    localparam state_t c_ST_WR_REQ  = 3'd4;
    localparam state_t c_ST_FINISH  = 3'd5;

    // Word pointers advance by one 32-bit word and wrap modulo 2^32.
    function automatic logic [31:0] ptr_next(input logic [31:0] i_ptr);
        return i_ptr + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_dma_regs.sv
`default_nettype none
// ============================================================================
// Module      : fir_dma_regs
// Description : Wishbone configuration slave for the FIR DMA engine. Holds
//               SRC_ADDR, DST_ADDR and LENGTH, returns CTRL status and
//               produces a one-cycle START pulse.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_wbs_*           - slave request (cyc, stb, we, word index, data)
//               o_wbs_ack/o_wbs_dat - registered 1-cycle ack and read data
//               i_busy, i_done    - status bits for CTRL readback
//               o_start           - START pulse (only while not busy)
//               o_src/o_dst/o_len - programmed block parameters
// Revision    : 1.0 - initial release
// ============================================================================
module fir_dma_regs
    import fir_dma_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wbs_cyc,
    input  logic              i_wbs_stb,
    input  logic              i_wbs_we,
    input  logic [1:0]        i_wbs_idx,
    input  logic [DATA_W-1:0] i_wbs_dat,
    output logic              o_wbs_ack,
    output logic [DATA_W-1:0] o_wbs_dat,
    input  logic              i_busy,
    input  logic              i_done,
    output logic              o_start,
    output logic [31:0]       o_src,
    output logic [31:0]       o_dst,
    output logic [LEN_W-1:0]  o_len
);

    logic              r_ack;
    logic [DATA_W-1:0] r_dat;
    logic              r_start;
    logic [31:0]       r_src;
    logic [31:0]       r_dst;
    logic [LEN_W-1:0]  r_len;

    logic              w_req;
    logic [DATA_W-1:0] w_rdata;

    // A request is serviced once; the ack cycle itself masks the still-held
    // cyc/stb so the same request is never acknowledged twice.
    assign w_req = i_wbs_cyc & i_wbs_stb & ~r_ack;

    always_comb begin
        w_rdata = '0;
        case (i_wbs_idx)
            c_REG_CTRL: begin
                w_rdata[c_CTRL_DONE] = i_done;
                w_rdata[c_CTRL_BUSY] = i_busy;
            end
            c_REG_SRC: w_rdata = DATA_W'(r_src);
            c_REG_DST: w_rdata = DATA_W'(r_dst);
            c_REG_LEN: w_rdata = DATA_W'(r_len);
            default:   w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_start <= 1'b0;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
        end else begin
            r_ack   <= w_req;
            r_dat   <= (w_req && !i_wbs_we) ? w_rdata : '0;
            r_start <= w_req & i_wbs_we & (i_wbs_idx == c_REG_CTRL)
                       & i_wbs_dat[c_CTRL_START] & ~i_busy;
            // Block parameters are frozen while a transfer is running.
            if (w_req && i_wbs_we && !i_busy) begin
                case (i_wbs_idx)
                    c_REG_SRC: r_src <= 32'(i_wbs_dat);
                    c_REG_DST: r_dst <= 32'(i_wbs_dat);
                    c_REG_LEN: r_len <= LEN_W'(i_wbs_dat);
                    default: ;
                endcase
            end
        end
    end

    assign o_wbs_ack = r_ack;
    assign o_wbs_dat = r_dat;
    assign o_start   = r_start;
    assign o_src     = r_src;
    assign o_dst     = r_dst;
    assign o_len     = r_len;

endmodule
`default_nettype wire

// File: rtl/fir_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_dma_ctrl
// Description : Single-channel DMA engine. Reads one sample from RAM, pushes
//               it to the FIR (ss_*), waits for the FIR result (sm_*), writes
//               it back to RAM, and repeats for LENGTH samples.
// Ports       : wb_clk_i, wb_rst_i - clock, synchronous active-high reset
//               wbs_*   - Wishbone config slave (CTRL/SRC/DST/LEN)
//               wbm_*   - Wishbone RAM master, single outstanding access
//               ss_*    - AXI-Stream sample output to FIR
//               sm_*    - AXI-Stream result input from FIR
//               done_irq - one-cycle pulse at block completion
// Revision    : 1.0 - initial release
// ============================================================================
module fir_dma_ctrl #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [DATA_W-1:0] wbs_dat_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [31:0]       wbm_adr_o,
    output logic [DATA_W-1:0] wbm_dat_o,
    input  logic              wbm_ack_i,
    input  logic [DATA_W-1:0] wbm_dat_i,
    output logic              ss_tvalid,
    output logic [DATA_W-1:0] ss_tdata,
    output logic              ss_tlast,
    input  logic              ss_tready,
    input  logic              sm_tvalid,
    input  logic [DATA_W-1:0] sm_tdata,
    input  logic              sm_tlast,
    output logic              sm_tready,
    output logic              done_irq
);

    import fir_dma_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_rd_ptr;
    logic [31:0]       r_wr_ptr;
    logic [LEN_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_sample;
    logic [DATA_W-1:0] r_result;
    logic              r_busy;
    logic              r_done;

    logic              w_start;
    logic [31:0]       w_src;
    logic [31:0]       w_dst;
    logic [LEN_W-1:0]  w_len;
    logic              w_last;

    // Byte selects, the undecoded address bits and the FIR last flag carry
    // no information for this engine.
    logic w_unused_bits;
    assign w_unused_bits = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0], sm_tlast};

    fir_dma_regs #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_regs (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .i_wbs_cyc (wbs_cyc_i),
        .i_wbs_stb (wbs_stb_i),
        .i_wbs_we  (wbs_we_i),
        .i_wbs_idx (wbs_adr_i[3:2]),
        .i_wbs_dat (wbs_dat_i),
        .o_wbs_ack (wbs_ack_o),
        .o_wbs_dat (wbs_dat_o),
        .i_busy    (r_busy),
        .i_done    (r_done),
        .o_start   (w_start),
        .o_src     (w_src),
        .o_dst     (w_dst),
        .o_len     (w_len)
    );

    assign w_last = (r_cnt == LEN_W'(1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and bus/stream outputs. Outputs are decoded from the state
    // register so that reset drops them on the very next cycle.
    always_comb begin
        w_state_nxt = r_state;
        wbm_cyc_o   = 1'b0;
        wbm_stb_o   = 1'b0;
        wbm_we_o    = 1'b0;
        wbm_adr_o   = '0;
        ss_tvalid   = 1'b0;
        ss_tlast    = 1'b0;
        sm_tready   = 1'b0;
        done_irq    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = (w_len != '0) ? c_ST_RD_REQ : c_ST_FINISH;
                end
            end
            c_ST_RD_REQ: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_adr_o = r_rd_ptr;
                if (wbm_ack_i) begin
                    w_state_nxt = c_ST_SS_PUSH;
                end
            end
            c_ST_SS_PUSH: begin
                ss_tvalid = 1'b1;
                ss_tlast  = w_last;
                if (ss_tready) begin
                    w_state_nxt = c_ST_SM_WAIT;
                end
            end
            c_ST_SM_WAIT: begin
                sm_tready = 1'b1;
                if (sm_tvalid) begin
                    w_state_nxt = c_ST_WR_REQ;
                end
            end
            c_ST_WR_REQ: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_adr_o = r_wr_ptr;
                if (wbm_ack_i) begin
                    // The count is decremented on this same edge.
                    w_state_nxt = w_last ? c_ST_FINISH : c_ST_RD_REQ;
                end
            end
            c_ST_FINISH: begin
                done_irq    = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_sample <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start && (w_len != '0)) begin
                        r_rd_ptr <= w_src;
                        r_wr_ptr <= w_dst;
                        r_cnt    <= w_len;
                        r_done   <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                c_ST_RD_REQ: begin
                    if (wbm_ack_i) begin
                        r_sample <= wbm_dat_i;
                        r_rd_ptr <= ptr_next(r_rd_ptr);
                    end
                end
                c_ST_SM_WAIT: begin
                    if (sm_tvalid) begin
                        r_result <= sm_tdata;
                    end
                end
                c_ST_WR_REQ: begin
                    if (wbm_ack_i) begin
                        r_wr_ptr <= ptr_next(r_wr_ptr);
                        r_cnt    <= r_cnt - LEN_W'(1);
                    end
                end
                c_ST_FINISH: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign wbm_sel_o = 4'hF;
    assign wbm_dat_o = r_result;
    assign ss_tdata  = r_sample;

endmodule
`default_nettype wire

// File: tb/tb_fir_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_dma_ctrl
// Description : Self-checking bench for fir_dma_ctrl with a RAM model, a
//               behavioural FIR stand-in and a block-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_dma_ctrl;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        ss_tvalid, ss_tlast, ss_tready;
    logic [31:0] ss_tdata;
    logic        sm_tvalid, sm_tlast, sm_tready;
    logic [31:0] sm_tdata;
    logic        done_irq;

    always #5 wb_clk_i = ~wb_clk_i;

    fir_dma_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
        .sm_tready(sm_tready),
        .done_irq (done_irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- RAM model (owns mem and the access logs) ----------------
    logic [31:0] mem [0:255];
    logic [31:0] init_mem [0:255];
    logic        load_req = 1'b0;
    int          ram_wait = 0;
    int          wcnt = 0;
    int          wr_count = 0;
    int          rd_count = 0;
    logic [31:0] wr_adr_log [0:127];
    logic [31:0] rd_adr_log [0:127];
    logic        ram_ack;

    assign ram_ack   = wbm_cyc_o && wbm_stb_o && (wcnt >= ram_wait);
    assign wbm_ack_i = ram_ack;
    assign wbm_dat_i = (ram_ack && !wbm_we_o) ? mem[wbm_adr_o[9:2]] : 32'hDEAD_BEEF;

    always @(posedge wb_clk_i) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
        end else if (wbm_cyc_o && wbm_stb_o) begin
            if (ram_ack) begin
                wcnt <= 0;
                if (wbm_we_o) begin
                    mem[wbm_adr_o[9:2]]      <= wbm_dat_o;
                    wr_adr_log[wr_count[6:0]] <= wbm_adr_o;
                    wr_count                 <= wr_count + 1;
                end else begin
                    rd_adr_log[rd_count[6:0]] <= wbm_adr_o;
                    rd_count                 <= rd_count + 1;
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    // ---------------- Event monitors ----------------
    int irq_count = 0;
    int cyc_count = 0;
    always @(posedge wb_clk_i) begin
        if (done_irq)  irq_count <= irq_count + 1;
        if (wbm_cyc_o) cyc_count <= cyc_count + 1;
    end

    // Master request must hold adr/dat/we until acknowledged.
    int          wb_viol = 0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_adr, prev_dat;
    logic        prev_we;
    always @(negedge wb_clk_i) begin
        if (prev_pend && wbm_cyc_o && wbm_stb_o &&
            (wbm_adr_o !== prev_adr || wbm_dat_o !== prev_dat || wbm_we_o !== prev_we))
            wb_viol <= wb_viol + 1;
        prev_pend <= wbm_cyc_o && wbm_stb_o && !ram_ack;
        prev_adr  <= wbm_adr_o;
        prev_dat  <= wbm_dat_o;
        prev_we   <= wbm_we_o;
    end

    // ---------------- FIR stand-in ----------------
    int          stall_max  = 0;
    int          sm_delay   = 0;
    bit          rand_stall = 1'b0;
    int          fir_mode   = 0;
    logic [31:0] ss_log [0:127];
    logic        ss_last_log [0:127];
    int          ss_count = 0;
    int          ss_viol  = 0;

    function automatic logic [31:0] fir_model(input logic [31:0] x, input int mode);
        return (mode == 0) ? x : (x * 32'd3 + 32'd7);
    endfunction

    initial begin
        logic [31:0] cap;
        int          st;
        ss_tready = 1'b0; sm_tvalid = 1'b0; sm_tdata = '0; sm_tlast = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (ss_tvalid === 1'b1 && wb_rst_i === 1'b0) begin
                cap = ss_tdata;
                st  = rand_stall ? int'($urandom_range(0, stall_max)) : stall_max;
                for (int k = 0; k < st; k++) begin
                    @(negedge wb_clk_i);
                    if (ss_tdata !== cap || ss_tvalid !== 1'b1) ss_viol++;
                end
                ss_log[ss_count[6:0]]      = ss_tdata;
                ss_last_log[ss_count[6:0]] = ss_tlast;
                ss_tready = 1'b1;
                @(negedge wb_clk_i);
                ss_tready = 1'b0;
                ss_count++;
                st = rand_stall ? int'($urandom_range(0, sm_delay)) : sm_delay;
                repeat (st) @(negedge wb_clk_i);
                sm_tvalid = 1'b1;
                sm_tdata  = fir_model(cap, fir_mode);
                sm_tlast  = ss_last_log[(ss_count - 1) & 127];
                @(negedge wb_clk_i);
                sm_tvalid = 1'b0;
                sm_tlast  = 1'b0;
            end
        end
    end

    // ---------------- Config bus helpers ----------------
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                             output logic [31:0] rdat, output bit got,
                             output logic ack_after, output logic [31:0] dat_after);
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = wdat;
        got = 1'b0; rdat = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) begin got = 1'b1; rdat = wbs_dat_o; end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge wb_clk_i); #1;
        ack_after = wbs_ack_o;
        dat_after = wbs_dat_o;
    endtask

    localparam logic [31:0] A_CTRL = 32'h3800_0080;
    localparam logic [31:0] A_SRC  = 32'h3800_0084;
    localparam logic [31:0] A_DST  = 32'h3800_0088;
    localparam logic [31:0] A_LEN  = 32'h3800_008C;

    task automatic reg_wr(input string tag, input logic [31:0] adr, input logic [31:0] d);
        logic [31:0] rd, da; bit got; logic aa;
        wb_access(1'b1, adr, d, rd, got, aa, da);
        check({tag, "_ack"}, {31'd0, got}, 32'd1);
    endtask

    task automatic reg_rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] rd, da; bit got; logic aa;
        wb_access(1'b0, adr, '0, rd, got, aa, da);
        check({tag, "_ack"}, {31'd0, got}, 32'd1);
        check(tag, rd, exp);
    endtask

    // ---------------- Block-level reference model ----------------
    logic [31:0] g_src, g_dst;
    int          g_len;
    logic [31:0] g_exp [0:63];
    int          b_wr, b_rd, b_irq, b_ss;

    task automatic prep(input logic [31:0] src, input logic [31:0] dst, input int len,
                        input int mode, input bit seq);
        for (int i = 0; i < 256; i++) init_mem[i] = $urandom;
        if (seq) for (int i = 0; i < len; i++) init_mem[((src >> 2) + i) & 255] = 32'(i + 1);
        for (int i = 0; i < len; i++)
            g_exp[i] = fir_model(init_mem[((src >> 2) + i) & 255], mode);
        g_src = src; g_dst = dst; g_len = len; fir_mode = mode;
        @(negedge wb_clk_i); load_req = 1'b1;
        @(negedge wb_clk_i); load_req = 1'b0;
        b_wr = wr_count; b_rd = rd_count; b_irq = irq_count; b_ss = ss_count;
    endtask

    task automatic program_and_start(input string tag);
        reg_wr({tag, "_src"}, A_SRC, g_src);
        reg_wr({tag, "_dst"}, A_DST, g_dst);
        reg_wr({tag, "_len"}, A_LEN, 32'(g_len));
        reg_wr({tag, "_start"}, A_CTRL, 32'h1);
    endtask

    task automatic wait_irq(input int base, input int bound, output bit ok);
        for (int i = 0; i < bound && irq_count == base; i++) begin
            @(posedge wb_clk_i); #1;
        end
        ok = (irq_count != base);
    endtask

    task automatic verify(input string tag);
        bit ok;
        wait_irq(b_irq, g_len * 400 + 50, ok);
        check({tag, "_done_seen"}, {31'd0, ok}, 32'd1);
        repeat (3) @(posedge wb_clk_i);
        #1;
        check({tag, "_irq_cnt"}, 32'(irq_count - b_irq), 32'd1);
        check({tag, "_wr_cnt"}, 32'(wr_count - b_wr), 32'(g_len));
        check({tag, "_rd_cnt"}, 32'(rd_count - b_rd), 32'(g_len));
        check({tag, "_ss_cnt"}, 32'(ss_count - b_ss), 32'(g_len));
        for (int i = 0; i < g_len; i++) begin
            check($sformatf("%s_rd_adr%0d", tag, i), rd_adr_log[(b_rd + i) & 127], g_src + 32'(4 * i));
            check($sformatf("%s_wr_adr%0d", tag, i), wr_adr_log[(b_wr + i) & 127], g_dst + 32'(4 * i));
            check($sformatf("%s_data%0d", tag, i), mem[((g_dst >> 2) + i) & 255], g_exp[i]);
            check($sformatf("%s_tlast%0d", tag, i), {31'd0, ss_last_log[(b_ss + i) & 127]},
                  (i == g_len - 1) ? 32'd1 : 32'd0);
        end
        reg_rd({tag, "_ctrl"}, A_CTRL, 32'h2);
        check({tag, "_wb_stable"}, 32'(wb_viol), 32'd0);
        check({tag, "_ss_stable"}, 32'(ss_viol), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    // ---------------- Directed sequence ----------------
    initial begin
        logic [31:0] rd, da;
        bit          got, ok;
        logic        aa;
        int          cb, ib, wb0, len;

        wb_rst_i = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'hF; wbs_adr_i = '0; wbs_dat_i = '0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
        check("rst_adr", wbm_adr_o, 32'd0);
        check("rst_sel", {28'd0, wbm_sel_o}, 32'hF);
        check("rst_ss_tvalid", {31'd0, ss_tvalid}, 32'd0);
        check("rst_sm_tready", {31'd0, sm_tready}, 32'd0);
        check("rst_irq", {31'd0, done_irq}, 32'd0);
        check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        @(negedge wb_clk_i); wb_rst_i = 1'b0;
        reg_rd("rst_ctrl", A_CTRL, 32'h0);
        reg_rd("rst_src", A_SRC, 32'h0);
        reg_rd("rst_len", A_LEN, 32'h0);

        // Register access and ack shape
        reg_wr("cfg_src", A_SRC, 32'h3800_0000);
        reg_wr("cfg_dst", A_DST, 32'h3800_0100);
        reg_wr("cfg_len_wide", A_LEN, 32'hFFFF_0005);
        reg_rd("cfg_len_upper", A_LEN, 32'h0000_0005);
        reg_wr("cfg_len", A_LEN, 32'd4);
        wb_access(1'b0, A_SRC, '0, rd, got, aa, da);
        check("rd_src", rd, 32'h3800_0000);
        check("ack_width", {31'd0, aa}, 32'd0);
        check("dat_idle_zero", da, 32'd0);
        reg_rd("rd_dst", A_DST, 32'h3800_0100);
        reg_rd("rd_len", A_LEN, 32'd4);
        reg_rd("rd_ctrl", A_CTRL, 32'h0);

        // Basic run: identity FIR, zero-wait RAM
        ram_wait = 0; stall_max = 0; sm_delay = 0; rand_stall = 1'b0;
        prep(32'h3800_0000, 32'h3800_0100, 4, 0, 1'b1);
        program_and_start("basic");
        verify("basic");

        // Backpressure and arbiter wait states
        ram_wait = 5; stall_max = 10; sm_delay = 7;
        prep(32'h3800_0000, 32'h3800_0100, 4, 1, 1'b0);
        program_and_start("stall");
        verify("stall");

        // Randomized blocks
        rand_stall = 1'b1; stall_max = 4; sm_delay = 4;
        for (int r = 0; r < 3; r++) begin
            ram_wait = int'($urandom_range(0, 3));
            len = int'($urandom_range(3, 8));
            prep(32'h3800_0040 + 32'(4 * $urandom_range(0, 8)),
                 32'h3800_0200 + 32'(4 * $urandom_range(0, 8)), len, 1, 1'b0);
            program_and_start($sformatf("rnd%0d", r));
            verify($sformatf("rnd%0d", r));
        end

        // LEN = 0 completes at once without touching RAM
        rand_stall = 1'b0; ram_wait = 0; stall_max = 0; sm_delay = 0;
        reg_wr("len0_len", A_LEN, 32'd0);
        cb = cyc_count; ib = irq_count;
        reg_wr("len0_start", A_CTRL, 32'h1);
        wait_irq(ib, 3, ok);
        check("len0_done_fast", {31'd0, ok}, 32'd1);
        reg_rd("len0_ctrl", A_CTRL, 32'h2);
        check("len0_no_cyc", 32'(cyc_count - cb), 32'd0);

        // START and SRC writes while busy are ignored
        stall_max = 30; sm_delay = 10; ram_wait = 1;
        prep(32'h3800_0000, 32'h3800_0100, 4, 0, 1'b0);
        program_and_start("busy");
        reg_rd("busy_ctrl", A_CTRL, 32'h4);
        reg_wr("busy_src_wr", A_SRC, 32'h1111_0000);
        reg_rd("busy_src_old", A_SRC, 32'h3800_0000);
        reg_wr("busy_restart", A_CTRL, 32'h1);
        verify("busy");
        cb = cyc_count;
        repeat (20) @(posedge wb_clk_i);
        #1;
        check("busy_no_rerun", 32'(cyc_count - cb), 32'd0);

        // Reset during the second sample's write
        stall_max = 0; sm_delay = 0; ram_wait = 6;
        prep(32'h3800_0000, 32'h3800_0100, 4, 0, 1'b0);
        wb0 = wr_count;
        program_and_start("rst_mid");
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge wb_clk_i);
            ok = (wr_count == wb0 + 1) && wbm_cyc_o && wbm_we_o;
        end
        check("rst_mid_reached_wr2", {31'd0, ok}, 32'd1);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        check("rst_mid_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("rst_mid_ss", {31'd0, ss_tvalid}, 32'd0);
        @(negedge wb_clk_i); wb_rst_i = 1'b0;
        reg_rd("rst_mid_ctrl", A_CTRL, 32'h0);
        check("rst_mid_wr_cnt", 32'(wr_count - wb0), 32'd1);
        ram_wait = 2;
        prep(32'h3800_0000, 32'h3800_0100, 4, 1, 1'b0);
        program_and_start("after_rst");
        verify("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_dma_ctrl.md
Name: fir_dma_ctrl

Overview:
Single-channel DMA engine that moves a block of samples from system RAM through the FIR and writes the filtered results back to RAM. The CPU programs it over a Wishbone slave port in the 0x3800_0080 window. It masters RAM through the DMA-side port of the SDRAM arbiter. It feeds the FIR over AXI-Stream (ss_*) and collects the FIR output over AXI-Stream (sm_*). Samples are processed one at a time: one input word in, one output word back.

Parameters:
DATA_W, 32, sample and Wishbone data width
LEN_W, 16, width of the length register (maximum 65535 samples)

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset; synchronous, active-high
wbs_cyc_i  in  1  config slave cycle
wbs_stb_i  in  1  config slave strobe
wbs_we_i  in  1  config write enable
wbs_sel_i  in  4  byte selects (ignored; full-word access only)
wbs_adr_i  in  32  config address; only bits [3:2] decoded
wbs_dat_i  in  32  config write data
wbs_ack_o  out  1  config acknowledge
wbs_dat_o  out  32  config read data
wbm_cyc_o  out  1  RAM master cycle (to arbiter DMA port)
wbm_stb_o  out  1  RAM master strobe
wbm_we_o  out  1  RAM master write enable
wbm_sel_o  out  4  byte selects; always 4'hF
wbm_adr_o  out  32  RAM address
wbm_dat_o  out  32  RAM write data
wbm_ack_i  in  1  RAM acknowledge
wbm_dat_i  in  32  RAM read data
ss_tvalid  out  1  sample to FIR valid
ss_tdata  out  DATA_W  sample to FIR
ss_tlast  out  1  marks the last sample of the block
ss_tready  in  1  FIR accepts sample
sm_tvalid  in  1  FIR result valid
sm_tdata  in  DATA_W  FIR result
sm_tlast  in  1  FIR last flag (sampled and ignored)
sm_tready  out  1  DMA accepts result
done_irq  out  1  one-cycle pulse at block completion

Behaviour:
- Register map at offset [3:2]:
  - 0 CTRL: bit0 START, write-1-to-start, reads 0. bit1 DONE, read-only, sticky. bit2 BUSY, read-only.
  - 1 SRC_ADDR.
  - 2 DST_ADDR.
  - 3 LENGTH, in samples; [LEN_W-1:0] used, upper bits read 0.
- Config slave timing:
  - wbs_ack_o pulses for 1 cycle, registered, the cycle after cyc&stb is seen. It never asserts on back-to-back cycles for the same request.
  - wbs_dat_o is valid with ack and is 0 otherwise.
  - Writes to SRC_ADDR, DST_ADDR and LENGTH while BUSY are acked but ignored.
  - START while BUSY is ignored.
- Reset values:
  - All registers 0.
  - All wbm_* outputs 0, except wbm_sel_o = 4'hF.
  - ss_tvalid = 0, sm_tready = 0, done_irq = 0, wbs_ack_o = 0.
  - State = IDLE.
- FSM states: IDLE, RD_REQ, SS_PUSH, SM_WAIT, WR_REQ, FINISH.
  - IDLE: on START with LENGTH ≠ 0:
    - load rd_ptr = SRC_ADDR, wr_ptr = DST_ADDR, cnt = LENGTH;
    - clear DONE, set BUSY, go to RD_REQ.
  - IDLE: on START with LENGTH = 0: go directly to FINISH.
  - RD_REQ: drive cyc = stb = 1, we = 0, adr = rd_ptr, held stable until wbm_ack_i.
    - On ack: latch wbm_dat_i into a sample register, drop cyc/stb the same edge, rd_ptr += 4, go to SS_PUSH.
  - SS_PUSH: ss_tvalid = 1 with tdata held stable; ss_tlast = 1 when cnt == 1.
    - Transfer occurs on tvalid & tready; then go to SM_WAIT.
  - SM_WAIT: sm_tready = 1. On sm_tvalid, latch sm_tdata and go to WR_REQ.
  - WR_REQ: cyc = stb = we = 1, adr = wr_ptr, dat = latched result.
    - On ack: drop cyc/stb, wr_ptr += 4, cnt -= 1.
    - Then go to FINISH if the new cnt == 0, else to RD_REQ.
  - FINISH: set DONE, clear BUSY, pulse done_irq for exactly 1 cycle, return to IDLE.
- Throughput: at most 1 sample per (RAM read latency + RAM write latency + FIR latency + 4) cycles. There is no pipelining across samples.
- Addresses: pointers are 32-bit and wrap modulo 2^32. The low 2 bits are passed through unchanged; there is no alignment check.
- Wishbone master: single outstanding access. Ack arriving in the same cycle stb first rises is legal (zero-wait slave).
- Reset mid-operation: reset returns to IDLE within one cycle and drops every master and stream output. A partially written block is not resumed.
- The CPU may read CTRL/BUSY at any time, including while the master port is active.

Decomposition:
- Package fir_dma_pkg: register offset constants (CTRL, SRC, DST, LEN), CTRL bit positions, FSM state enum.
- One natural sub-module, fir_dma_regs: config slave, register file and START pulse generation.
- The FSM and datapath stay in fir_dma_ctrl.

Test Plan:
- Register access: write SRC=0x3800_0000, DST=0x3800_0100, LEN=4; read back. Values match, CTRL reads 0, each ack is 1 cycle wide.
- Basic run: preload RAM with 1,2,3,4 and use an identity FIR model. START → 4 reads at 0x3800_0000..0C, 4 writes at 0x3800_0100..10C with data 1..4; ss_tlast only on the 4th sample; DONE=1; one done_irq pulse.
- Backpressure: hold ss_tready=0 for 10 cycles and delay sm_tvalid by 7 cycles. ss_tdata stays stable while stalled and the RAM contents are still correct.
- Arbiter stall: insert 0 and 5 wait states on wbm_ack_i. adr, dat and we are held stable until ack; no duplicate writes occur.
- Edge cases:
  - LEN=0 + START → DONE within 2 cycles, no wbm_cyc_o.
  - START while BUSY → ignored.
  - SRC write while BUSY → readback shows the old value.
- Reset at the 2nd sample's WR_REQ → wbm_cyc_o = 0 on the next cycle; BUSY=0, DONE=0; a new START then runs correctly.
